// File: rtl/aes_stream_ctrl.sv
// Stream front-end for an AES core: collects an 8-word job (key + text),
// issues it to the core, waits for the result and drains it downstream.
module aes_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_mode,
    input  logic        s_kld,
    output logic        aes_ld,
    output logic [31:0] aes_key,
    output logic [31:0] aes_text,
    output logic        aes_kld,
    output logic        aes_mode,
    input  logic        aes_done,
    input  logic [31:0] aes_text_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t        state_r;
    logic [31:0]   word_r [0:7];
    logic [31:0]   res_r  [0:3];
    logic [2:0]    cnt_r;
    logic [1:0]    idx_r;
    logic [TW-1:0] timer_r;
    logic          mode_r;
    logic          kld_r;

    // Job FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_COLLECT;
            cnt_r       <= 3'd0;
            idx_r       <= 2'd0;
            timer_r     <= '0;
            mode_r      <= 1'b0;
            kld_r       <= 1'b0;
            s_ready     <= 1'b0;
            aes_ld      <= 1'b0;
            aes_key     <= 32'd0;
            aes_text    <= 32'd0;
            aes_kld     <= 1'b0;
            aes_mode    <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= 32'd0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            for (int k = 0; k < 8; k++) word_r[k] <= 32'd0;
            for (int k = 0; k < 4; k++) res_r[k] <= 32'd0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (s_valid && s_ready) begin
                        word_r[cnt_r] <= s_data;
                        busy          <= 1'b1;
                        if (cnt_r == 3'd0) begin
                            mode_r <= s_mode;
                            kld_r  <= s_kld;
                        end
                        if (cnt_r == 3'd7) begin
                            // word 0 and word 4 were stored in earlier cycles
                            cnt_r    <= 3'd0;
                            idx_r    <= 2'd0;
                            state_r  <= ST_ISSUE;
                            s_ready  <= 1'b0;
                            aes_ld   <= 1'b1;
                            aes_key  <= word_r[0];
                            aes_text <= word_r[4];
                            aes_kld  <= kld_r & mode_r;
                            aes_mode <= mode_r;
                        end else begin
                            cnt_r   <= cnt_r + 3'd1;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        s_ready <= 1'b1;
                        busy    <= (cnt_r != 3'd0);
                    end
                end
                ST_ISSUE: begin
                    if (idx_r == 2'd3) begin
                        state_r  <= ST_WAIT;
                        timer_r  <= '0;
                        aes_ld   <= 1'b0;
                        aes_key  <= 32'd0;
                        aes_text <= 32'd0;
                        aes_kld  <= 1'b0;
                    end else begin
                        idx_r    <= idx_r + 2'd1;
                        aes_key  <= word_r[{1'b0, idx_r + 2'd1}];
                        aes_text <= word_r[{1'b1, idx_r + 2'd1}];
                    end
                end
                ST_WAIT: begin
                    // a done pulse in the final timeout cycle still wins
                    if (aes_done) begin
                        res_r[0] <= aes_text_out;
                        idx_r    <= 2'd1;
                        state_r  <= ST_CAPTURE;
                    end else if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state_r     <= ST_COLLECT;
                        s_ready     <= 1'b1;
                        busy        <= 1'b0;
                        aes_mode    <= 1'b0;
                        timer_r     <= '0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_CAPTURE: begin
                    res_r[idx_r] <= aes_text_out;
                    if (idx_r == 2'd3) begin
                        idx_r    <= 2'd0;
                        state_r  <= ST_DRAIN;
                        m_valid  <= 1'b1;
                        m_data   <= res_r[0];
                        m_last   <= 1'b0;
                        aes_mode <= 1'b0;
                    end else begin
                        idx_r <= idx_r + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (idx_r == 2'd3) begin
                            idx_r   <= 2'd0;
                            state_r <= ST_COLLECT;
                            m_valid <= 1'b0;
                            m_data  <= 32'd0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            idx_r  <= idx_r + 2'd1;
                            m_data <= res_r[idx_r + 2'd1];
                            m_last <= (idx_r == 2'd2);
                        end
                    end else begin
                        m_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_COLLECT;
                    cnt_r    <= 3'd0;
                    idx_r    <= 2'd0;
                    s_ready  <= 1'b0;
                    aes_ld   <= 1'b0;
                    aes_kld  <= 1'b0;
                    aes_mode <= 1'b0;
                    m_valid  <= 1'b0;
                    m_last   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl; the bench plays the AES core and the
// downstream sink, with hand-computed expected words.
module tb_aes_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, s_mode, s_kld;
    logic [31:0] s_data;
    logic        aes_ld, aes_kld, aes_mode, aes_done;
    logic [31:0] aes_key, aes_text, aes_text_out;
    logic        m_valid, m_ready, m_last, busy, timeout_err;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] key_w [4];
    logic [31:0] txt_w [4];
    logic [31:0] res_w [4];

    always #5 clk = ~clk;

    aes_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_mode(s_mode), .s_kld(s_kld),
        .aes_ld(aes_ld), .aes_key(aes_key), .aes_text(aes_text),
        .aes_kld(aes_kld), .aes_mode(aes_mode),
        .aes_done(aes_done), .aes_text_out(aes_text_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Feed 8 words; later words carry inverted mode and kld=0 to prove they are ignored.
    task automatic send_job(input logic mode, input logic kld, input bit gappy);
        for (int w = 0; w < 8; w++) begin
            int k;
            k = 0;
            s_valid = 1'b1;
            s_data  = (w < 4) ? key_w[w] : txt_w[w-4];
            s_mode  = (w == 0) ? mode : ~mode;
            s_kld   = (w == 0) ? kld : 1'b0;
            @(negedge clk);
            while (!s_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) chk("s_ready_wait", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
            s_valid = 1'b0; s_data = 32'd0; s_mode = 1'b0; s_kld = 1'b0;
            if (gappy && w < 7) begin
                @(negedge clk);
                chk("gap_no_issue", 32'(aes_ld), 32'd0);
                chk("gap_busy", 32'(busy), 32'd1);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_issue(input logic exp_kld, input logic exp_mode);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("issue_ld%0d", i), 32'(aes_ld), 32'd1);
            chk($sformatf("issue_key%0d", i), aes_key, key_w[i]);
            chk($sformatf("issue_text%0d", i), aes_text, txt_w[i]);
            chk($sformatf("issue_kld%0d", i), 32'(aes_kld), 32'(exp_kld));
            chk($sformatf("issue_mode%0d", i), 32'(aes_mode), 32'(exp_mode));
            chk($sformatf("issue_sready%0d", i), 32'(s_ready), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Core model: done in WAIT cycle d, then result words on consecutive cycles.
    task automatic core_respond(input int d, input logic exp_mode);
        @(negedge clk);
        chk("wait_ld_off", 32'(aes_ld), 32'd0);
        chk("wait_kld_off", 32'(aes_kld), 32'd0);
        repeat (d) begin @(posedge clk); #1; end
        aes_done = 1'b1; aes_text_out = res_w[0];
        @(posedge clk); #1;
        aes_done = 1'b0;
        for (int r = 1; r < 4; r++) begin
            aes_text_out = res_w[r];
            @(negedge clk);
            chk("capture_mode", 32'(aes_mode), 32'(exp_mode));
            chk("capture_no_mvalid", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
        end
        aes_text_out = 32'd0;
    endtask

    task automatic drain(input int stall_word, input int stall_cycles);
        logic [31:0] held;
        for (int j = 0; j < 4; j++) begin
            if (j == stall_word) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    if (s == 0) held = m_data;
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", m_data, res_w[j]);
                    chk("stall_stable", m_data, held);
                    chk("stall_sready", 32'(s_ready), 32'd0);
                    @(posedge clk); #1;
                end
            end
            m_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("drain_valid%0d", j), 32'(m_valid), 32'd1);
            chk($sformatf("drain_data%0d", j), m_data, res_w[j]);
            chk($sformatf("drain_last%0d", j), 32'(m_last), 32'(j == 3));
            chk($sformatf("drain_mode%0d", j), 32'(aes_mode), 32'd0);
            chk($sformatf("drain_sready%0d", j), 32'(s_ready), 32'd0);
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
        @(negedge clk);
        chk("post_drain_valid", 32'(m_valid), 32'd0);
        chk("post_drain_sready", 32'(s_ready), 32'd1);
        chk("post_drain_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_mode = 1'b0; s_kld = 1'b0;
        aes_done = 1'b0; aes_text_out = 32'd0; m_ready = 1'b0;
        key_w = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        txt_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        res_w = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_ld", 32'(aes_ld), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_sready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Encrypt; kld requested but mode 0 so core kld stays low
        send_job(1'b0, 1'b1, 1'b0);
        check_issue(1'b0, 1'b0);
        core_respond(0, 1'b0);
        drain(-1, 0);

        // Decrypt with key load, gappy input, done in the timeout cycle, backpressure
        txt_w = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
        res_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        send_job(1'b1, 1'b1, 1'b1);
        check_issue(1'b1, 1'b1);
        core_respond(7, 1'b1);
        drain(1, 5);
        @(negedge clk);
        chk("done_wins_terr", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;

        // Timeout: core never answers
        send_job(1'b0, 1'b0, 1'b0);
        check_issue(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("to_terr_low", 32'(timeout_err), 32'd0);
            chk("to_no_mvalid", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_terr_set", 32'(timeout_err), 32'd1);
        chk("to_sready", 32'(s_ready), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_mvalid", 32'(m_valid), 32'd0);
        @(posedge clk); #1;

        // Normal job after timeout; mode 1 without kld
        res_w = '{32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'h0BADC0DE};
        send_job(1'b1, 1'b0, 1'b0);
        check_issue(1'b0, 1'b1);
        core_respond(2, 1'b1);
        drain(-1, 0);
        @(negedge clk);
        chk("terr_sticky", 32'(timeout_err), 32'd1);
        @(posedge clk); #1;

        // Reset in CAPTURE after r1 has been latched
        send_job(1'b0, 1'b0, 1'b0);
        check_issue(1'b0, 1'b0);
        @(negedge clk);
        aes_done = 1'b1; aes_text_out = res_w[0];
        @(posedge clk); #1;
        aes_done = 1'b0; aes_text_out = res_w[1];
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_sready", 32'(s_ready), 32'd0);
        chk("mid_rst_mvalid", 32'(m_valid), 32'd0);
        chk("mid_rst_mode", 32'(aes_mode), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_terr", 32'(timeout_err), 32'd0);
        chk("mid_rst_mdata", m_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aes_done = 1'b1;
        @(posedge clk); #1;
        aes_done = 1'b0; aes_text_out = 32'd0;
        @(negedge clk);
        chk("rel_sready", 32'(s_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("rel_no_mvalid", 32'(m_valid), 32'd0);
            chk("rel_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles the block waits for aes_done after issuing a job.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s_valid  input  1  upstream word valid.
REQ-005 s_ready  output  1  block accepts s_data this cycle.
REQ-006 s_data  input  32  job word: words 0-3 key (MSW first), words 4-7 text (MSW first).
REQ-007 s_mode  input  1  job mode (0 encrypt, 1 decrypt), sampled with word 0 only.
REQ-008 s_kld  input  1  new decrypt key request, sampled with word 0 only.
REQ-009 aes_ld  output  1  load strobe to AES core, high 4 cycles per job.
REQ-010 aes_key  output  32  key word to core during aes_ld.
REQ-011 aes_text  output  32  text word to core during aes_ld.
REQ-012 aes_kld  output  1  key-load qualifier to core.
REQ-013 aes_mode  output  1  mode select to core.
REQ-014 aes_done  input  1  core result-ready pulse.
REQ-015 aes_text_out  input  32  core result word stream.
REQ-016 m_valid  output  1  result word valid.
REQ-017 m_ready  input  1  downstream accepts m_data.
REQ-018 m_data  output  32  result word, MSW first.
REQ-019 m_last  output  1  high with result word 3.
REQ-020 busy  output  1  high when state is not COLLECT or word count nonzero.
REQ-021 timeout_err  output  1  sticky timeout flag.

Function
REQ-022 States SHALL be COLLECT, ISSUE, WAIT, CAPTURE, DRAIN; exactly one active.
REQ-023 COLLECT: s_ready=1; each s_valid&&s_ready stores s_data at index 0..7 (3-bit count) and increments count.
REQ-024 s_mode/s_kld SHALL be captured only on index-0 accept; later values ignored.
REQ-025 Accept of index 7 SHALL move to ISSUE next cycle and clear count; s_ready=0 in every other state.
REQ-026 ISSUE: 4 cycles, i=0..3; aes_ld=1, aes_key=key[i], aes_text=text[i]; then WAIT.
REQ-027 aes_kld SHALL equal captured kld AND captured mode during ISSUE, else 0.
REQ-028 aes_mode SHALL hold captured mode from first ISSUE cycle until CAPTURE ends; 0 otherwise.
REQ-029 WAIT: cycle counter increments from 0; aes_done=1 in cycle T latches aes_text_out as r0 and enters CAPTURE.
REQ-030 CAPTURE: latch aes_text_out in T+1, T+2, T+3 as r1, r2, r3; then DRAIN; m_valid first high at T+4.
REQ-031 Timeout: counter reaching TIMEOUT_CYCLES in WAIT without aes_done SHALL set timeout_err, discard job, return to COLLECT; no output words.
REQ-032 aes_done outside WAIT SHALL be ignored; aes_done in the timeout cycle SHALL win (capture, no error).
REQ-033 DRAIN: m_valid=1, m_data=r[j]; j advances on m_valid&&m_ready; m_last=1 when j=3.
REQ-034 m_data/m_last SHALL stay stable while m_valid&&!m_ready.
REQ-035 Accept of word 3 SHALL return to COLLECT next cycle; next job accept possible that cycle.
REQ-036 Output backpressure SHALL stall only DRAIN; core never relaunched before all 4 results drain.

Reset
REQ-037 While rst=1: state COLLECT, count/i/j/timer 0, all outputs 0 (s_ready=0, timeout_err=0).
REQ-038 First cycle after rst deasserts: s_ready=1.
REQ-039 rst in any state SHALL abort job and discard partial words/results, no further output.

Verification
REQ-040 Encrypt: key 000102..0F, text 00112233..EEFF, mode 0 -> aes_ld 4 cycles with words MSW first, aes_kld=0; core done -> m_data 69C4E0D8,6A7B0430,D8CDB780,70B4C55A, m_last on 4th.
REQ-041 Decrypt with kld: s_mode=1, s_kld=1 on word 0, s_kld=0 later -> aes_kld=1 all 4 ISSUE cycles, aes_mode=1 through CAPTURE.
REQ-042 Gappy input: s_valid toggled every other cycle -> 8 words collected in order, ISSUE starts after 8th accept.
REQ-043 Backpressure: m_ready low 5 cycles at word 1 -> m_data held; s_ready stays 0 until word 3 accepted.
REQ-044 Timeout: TIMEOUT_CYCLES=8, aes_done never -> timeout_err=1 after 8 WAIT cycles, m_valid never, next job accepted normally, timeout_err still 1.
REQ-045 Reset in CAPTURE after r1 -> all outputs 0, s_ready=1 next cycle, no m_valid.
